load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Execute-stage memory pipe directly upstream of commit_stage. Accepts one load or store from
//  issue, computes the effective address, and completes the operation:
//  - stores: post address/data into the store-buffer entry allocated at rename;
//  - loads: read data memory (1-cycle sync read) with store-buffer bypass, then write the phys reg.
//  Produces exe_sb_*, exe_w_*, exe_mem_addr and the load-bypass query consumed by commit_stage.
// PARAMETERS
//  WORD_SIZE_P   16  data/address width (word-addressed memory)
//  NUM_PHYS_REG  32  physical registers; PR_W = $clog2(NUM_PHYS_REG)
//  SB_ENTRY      8   store-buffer entries; SB_W = $clog2(SB_ENTRY)
//  ROB_ENTRY     16  ROB entries; ROB_W = $clog2(ROB_ENTRY)
// PORTS
//  clk_i                   in   1            clock, all state on rising edge
//  reset_i                 in   1            synchronous reset, ACTIVE-LOW (0 = reset)
//  issue_v_i               in   1            issue presents an op
//  issue_ready_o           out  1            LSU accepts op this cycle (v & ready = accept)
//  issue_is_store_i        in   1            1 store, 0 load
//  issue_base_i            in   WORD_SIZE_P  base register value
//  issue_offset_i          in   WORD_SIZE_P  sign-extended immediate
//  issue_st_data_i         in   WORD_SIZE_P  store data (ignored for loads)
//  issue_dst_i             in   PR_W         load destination phys reg
//  issue_rob_i             in   ROB_W        ROB entry of op
//  issue_sb_num_i          in   SB_W         store: own SB entry; load: youngest older SB entry
//  exe_mem_addr_o          out  WORD_SIZE_P  data-memory read address
//  exe_mem_data_i          in   WORD_SIZE_P  read data, valid 1 cycle after address
//  exe_ld_bypass_addr_o    out  WORD_SIZE_P  bypass query address
//  exe_ld_bypass_sb_num_o  out  SB_W         bypass query SB bound
//  sb_ld_bypass_valid_i    in   1            same-cycle (comb) bypass hit
//  sb_ld_bypass_value_i    in   WORD_SIZE_P  bypass data
//  exe_sb_v_o              out  1            store-buffer fill pulse
//  exe_sb_o                out  SB_W+2*W     {sb_num, addr, data}
//  exe_w_v_o               out  1            phys-reg write pulse
//  exe_addr_o              out  PR_W         phys-reg index
//  exe_data_o              out  WORD_SIZE_P  phys-reg data
//  cdb_v_o                 out  1            completion broadcast pulse
//  cdb_rob_o               out  ROB_W        completing ROB entry
//  rob_mispredict_i        in   1            flush all in-flight work
// BEHAVIOUR
//  - Reset (reset_i=0 at posedge): state=IDLE, all _v_o outputs 0, data/addr outputs 0.
//    issue_ready_o=0 while reset_i=0. Reset mid-op drops the op; no pulse.
//  - addr = (issue_base_i + issue_offset_i) mod 2^WORD_SIZE_P; computed and latched at accept.
//  - FSM states: IDLE, ST_DONE, LD_REQ, LD_DONE.
//    - IDLE:    ready=1. Accept store -> ST_DONE. Accept load -> LD_REQ.
//    - ST_DONE: exe_sb_v_o=1, exe_sb_o={sb_num, addr, data}; cdb_v_o=1 with latched rob.
//               ready=1; back-to-back accept allowed (-> ST_DONE/LD_REQ), else -> IDLE.
//    - LD_REQ:  ready=0. exe_mem_addr_o = exe_ld_bypass_addr_o = latched addr;
//               exe_ld_bypass_sb_num_o = latched sb_num. Register bypass hit/value. -> LD_DONE.
//    - LD_DONE: exe_w_v_o=1, exe_addr_o=dst, exe_data_o = bypass hit ? bypass value
//               : exe_mem_data_i; cdb_v_o=1. ready=1; same accept rules as ST_DONE.
//  - Latency: store accepted cycle T -> pulses at T+1. Load accepted at T -> pulses at T+2.
//  - Outside their states all _v_o are 0. exe_mem_addr_o holds last value (don't care).
//  - All pulses are single-cycle; commit_stage never back-pressures.
//  - rob_mispredict_i=1 in any cycle:
//    - suppresses every _v_o pulse that cycle;
//    - forces issue_ready_o=0 (no accept);
//    - next state = IDLE.
//  - Bypass priority: SB hit always wins over memory (youngest older store is newer than memory).
// TESTING
//  1 Store base=0x0010 off=0xFFFE data=0xBEEF sb=3 rob=5 -> T+1: exe_sb_v_o=1,
//    exe_sb_o={3,0x000E,0xBEEF}, cdb_rob_o=5; no exe_w_v_o.
//  2 mem[0x0040]=0x1234, no SB hit; load base=0x0040 off=0 dst=7 rob=2 -> T+2: exe_w_v_o=1,
//    exe_addr_o=7, exe_data_o=0x1234, cdb_rob_o=2.
//  3 Same load, bypass_valid=1 value=0xAAAA in LD_REQ -> T+2 exe_data_o=0xAAAA.
//  4 Store then load issued back-to-back (v held high) -> accepts at T and T+1;
//    pulses at T+1 (sb) and T+3 (load wb).
//  5 Load accepted T, rob_mispredict_i=1 at T+1 -> no pulses at T+2, ready=1 at T+2 (IDLE).
//  6 reset_i=0 during LD_DONE cycle -> no exe_w_v_o; next cycle all outputs 0, state IDLE.
//    Wrap: base=0xFFFF off=2 -> addr 0x0001.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : load_store_unit                                              |
// | Description : Execute-stage memory pipe. Computes the effective address of |
// |               one load/store at a time; stores post {sb, addr, data} to    |
// |               the store buffer, loads read data memory (1-cycle sync read) |
// |               with store-buffer bypass and write the destination reg.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int WORD_SIZE_P  = 16,
  parameter int NUM_PHYS_REG = 32,
  parameter int SB_ENTRY     = 8,
  parameter int ROB_ENTRY    = 16,
  localparam int PR_W        = $clog2(NUM_PHYS_REG),
  localparam int SB_W        = $clog2(SB_ENTRY),
  localparam int ROB_W       = $clog2(ROB_ENTRY)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          issue_v_i,
  output logic                          issue_ready_o,
  input  logic                          issue_is_store_i,
  input  logic [WORD_SIZE_P-1:0]        issue_base_i,
  input  logic [WORD_SIZE_P-1:0]        issue_offset_i,
  input  logic [WORD_SIZE_P-1:0]        issue_st_data_i,
  input  logic [PR_W-1:0]               issue_dst_i,
  input  logic [ROB_W-1:0]              issue_rob_i,
  input  logic [SB_W-1:0]               issue_sb_num_i,
  output logic [WORD_SIZE_P-1:0]        exe_mem_addr_o,
  input  logic [WORD_SIZE_P-1:0]        exe_mem_data_i,
  output logic [WORD_SIZE_P-1:0]        exe_ld_bypass_addr_o,
  output logic [SB_W-1:0]               exe_ld_bypass_sb_num_o,
  input  logic                          sb_ld_bypass_valid_i,
  input  logic [WORD_SIZE_P-1:0]        sb_ld_bypass_value_i,
  output logic                          exe_sb_v_o,
  output logic [SB_W+2*WORD_SIZE_P-1:0] exe_sb_o,
  output logic                          exe_w_v_o,
  output logic [PR_W-1:0]               exe_addr_o,
  output logic [WORD_SIZE_P-1:0]        exe_data_o,
  output logic                          cdb_v_o,
  output logic [ROB_W-1:0]              cdb_rob_o,
  input  logic                          rob_mispredict_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ST_DONE = 2'd1,
    S_LD_REQ  = 2'd2,
    S_LD_DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD_SIZE_P-1:0] addr_q, addr_d;
  logic [WORD_SIZE_P-1:0] data_q, data_d;
  logic [SB_W-1:0]        sb_q, sb_d;
  logic [PR_W-1:0]        dst_q, dst_d;
  logic [ROB_W-1:0]       rob_q, rob_d;
  logic                   byp_hit_q, byp_hit_d;
  logic [WORD_SIZE_P-1:0] byp_val_q, byp_val_d;

  // A flush or an asserted reset kills every pulse and blocks new accepts.
  logic active;
  logic accept;

  assign active = reset_i & ~rob_mispredict_i;

  // The latched address drives both the memory read and the bypass query.
  assign exe_mem_addr_o         = addr_q;
  assign exe_ld_bypass_addr_o   = addr_q;
  assign exe_ld_bypass_sb_num_o = sb_q;

  // Next-state, operand capture and completion outputs.
  always_comb begin
    state_d       = S_IDLE;
    addr_d        = addr_q;
    data_d        = data_q;
    sb_d          = sb_q;
    dst_d         = dst_q;
    rob_d         = rob_q;
    byp_hit_d     = byp_hit_q;
    byp_val_d     = byp_val_q;
    issue_ready_o = 1'b0;
    exe_sb_v_o    = 1'b0;
    exe_sb_o      = '0;
    exe_w_v_o     = 1'b0;
    exe_addr_o    = '0;
    exe_data_o    = '0;
    cdb_v_o       = 1'b0;
    cdb_rob_o     = '0;
    accept        = 1'b0;

    case (state_q)
      S_IDLE: begin
        issue_ready_o = active;
      end
      S_ST_DONE: begin
        issue_ready_o = active;
        if (active) begin
          exe_sb_v_o = 1'b1;
          exe_sb_o   = {sb_q, addr_q, data_q};
          cdb_v_o    = 1'b1;
          cdb_rob_o  = rob_q;
        end
      end
      S_LD_REQ: begin
        // Bypass answer arrives combinationally while the memory read is in flight.
        state_d   = S_LD_DONE;
        byp_hit_d = sb_ld_bypass_valid_i;
        byp_val_d = sb_ld_bypass_value_i;
      end
      S_LD_DONE: begin
        issue_ready_o = active;
        if (active) begin
          exe_w_v_o  = 1'b1;
          exe_addr_o = dst_q;
          // A buffered older store is always newer than memory contents.
          exe_data_o = byp_hit_q ? byp_val_q : exe_mem_data_i;
          cdb_v_o    = 1'b1;
          cdb_rob_o  = rob_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept = issue_v_i & issue_ready_o;
    if (accept) begin
      state_d = issue_is_store_i ? S_ST_DONE : S_LD_REQ;
      addr_d  = issue_base_i + issue_offset_i;
      data_d  = issue_st_data_i;
      sb_d    = issue_sb_num_i;
      dst_d   = issue_dst_i;
      rob_d   = issue_rob_i;
    end

    if (rob_mispredict_i) begin
      state_d = S_IDLE;
    end
  end

  // State and operand registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      sb_q      <= '0;
      dst_q     <= '0;
      rob_q     <= '0;
      byp_hit_q <= 1'b0;
      byp_val_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sb_q      <= sb_d;
      dst_q     <= dst_d;
      rob_q     <= rob_d;
      byp_hit_q <= byp_hit_d;
      byp_val_q <= byp_val_d;
    end
  end

endmodule
`default_nettype wire
